// File: rtl/mem_ctrl.sv
// Request-side front end for the Mem_ex single-port memory: valid/ready requests in,
// read/wr/addr/dq sequencing out. Optional burst reads are enabled with MEM_CTRL_BURST_EN.
module mem_ctrl #(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [AW-1:0] req_len,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          busy,
  output logic          mem_read,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_dq
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  localparam int          CW       = 3;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [AW-1:0] rsp_addr_q, rsp_addr_d;
  logic          rsp_last_q, rsp_last_d;
  logic          busy_q, busy_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef MEM_CTRL_BURST_EN
  logic [AW-1:0] len_q, len_d;
`else
  logic          len_unused;
  assign len_unused = ^req_len;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = 1'b0;
    mem_read_d  = mem_read_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
`ifdef MEM_CTRL_BURST_EN
    len_d       = len_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        mem_read_d  = 1'b0;
        mem_wr_d    = 1'b0;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          mem_addr_d  = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = '0;
`ifdef MEM_CTRL_BURST_EN
          len_d       = req_wr ? '0 : req_len;
`endif
          if (req_wr) begin
            state_d  = WRITE;
            mem_wr_d = 1'b1;
          end else begin
            state_d    = READ;
            mem_read_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d     = IDLE;
        mem_wr_d    = 1'b0;
        req_ready_d = 1'b1;
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          // Beat ends here: the memory has had RD_LAT cycles to present data.
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_dq;
          rsp_addr_d  = mem_addr_q;
          cnt_d       = '0;
`ifdef MEM_CTRL_BURST_EN
          rsp_last_d  = (len_q == '0);
          if (len_q != '0) begin
            len_d      = len_q - AW'(1);
            mem_addr_d = mem_addr_q + AW'(1);
          end else begin
            state_d    = TURN;
            mem_read_d = 1'b0;
          end
`else
          state_d    = TURN;
          mem_read_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TURN: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
`ifdef MEM_CTRL_BURST_EN
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
`ifdef MEM_CTRL_BURST_EN
      len_q       <= len_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;
  assign mem_read  = mem_read_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  // Bus is driven only by the registered write strobe, so reset releases it at once.
  assign mem_dq    = mem_wr_q ? wdata_q : {DW{1'bz}};

endmodule
